// File: rtl/matrix_window_ctrl.sv
// matrix_window_ctrl
// Sequencer in front of the 3x3 line-buffer window generator. Re-times the
// camera stream, appends one pad pixel per line and one flush line per frame
// so every image pixel reaches the window centre, and produces centre
// coordinates plus valid/border flags aligned with the generator's matrix
// outputs. Line-length and frame-structure errors are flagged as sticky bits.
module matrix_window_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int CNT_W      = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  per_frame_vsync,
  input  logic                  per_frame_href,
  input  logic                  per_frame_clken,
  input  logic [DATA_WIDTH-1:0] per_img_y,
  output logic                  gen_frame_vsync,
  output logic                  gen_frame_href,
  output logic                  gen_frame_clken,
  output logic [DATA_WIDTH-1:0] gen_img_y,
  output logic                  win_valid,
  output logic                  win_border,
  output logic [CNT_W-1:0]      win_x,
  output logic [CNT_W-1:0]      win_y,
  output logic                  frame_done,
  output logic                  line_len_err,
  output logic                  frame_err
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] COL_SAT  = CNT_W'(IMG_W + 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVE,
    S_PAD,
    S_GAP,
    S_FLUSH,
    S_WAIT_VS
  } state_t;

  state_t           state;
  logic             vsync_q;
  logic             href_q;
  logic [CNT_W-1:0] pix_cnt;
  logic [CNT_W-1:0] in_row;
  logic [CNT_W-1:0] flush_cnt;

  logic [CNT_W-1:0] col_cnt;
  logic [CNT_W-1:0] row_cnt;
  logic             gen_href_q;
  logic             win_hit;
  logic             win_edge;
  logic             s1_valid;
  logic             s1_border;
  logic [CNT_W-1:0] s1_x;
  logic [CNT_W-1:0] s1_y;

  // A generator clock enable produces an image-pixel centre only once one
  // full column and one full row have been pushed in ahead of it.
  assign win_hit  = gen_frame_href && gen_frame_clken &&
                    (col_cnt >= ONE) && (col_cnt <= LAST_COL) &&
                    (row_cnt >= ONE) && (row_cnt <= LAST_ROW);
  assign win_edge = (col_cnt == ONE) || (col_cnt == LAST_COL) ||
                    (row_cnt == ONE) || (row_cnt == LAST_ROW);

  // Frame sequencer: drives the generator stream, injects pad/flush and tracks errors.
  // vsync_q resets high so a frame already in progress at reset release is
  // not mistaken for a new frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      vsync_q         <= 1'b1;
      href_q          <= 1'b0;
      pix_cnt         <= '0;
      in_row          <= '0;
      flush_cnt       <= '0;
      gen_frame_vsync <= 1'b0;
      gen_frame_href  <= 1'b0;
      gen_frame_clken <= 1'b0;
      gen_img_y       <= '0;
      frame_done      <= 1'b0;
      line_len_err    <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      vsync_q    <= per_frame_vsync;
      href_q     <= per_frame_href;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          gen_frame_vsync <= 1'b0;
          gen_frame_href  <= 1'b0;
          gen_frame_clken <= 1'b0;
          gen_img_y       <= '0;
          pix_cnt         <= '0;
          if (per_frame_vsync && !vsync_q) begin
            state           <= S_ACTIVE;
            line_len_err    <= 1'b0;
            frame_err       <= 1'b0;
            in_row          <= '0;
            gen_frame_vsync <= 1'b1;
            gen_frame_href  <= per_frame_href;
            gen_frame_clken <= per_frame_clken;
            gen_img_y       <= per_img_y;
          end
        end
        S_ACTIVE: begin
          if (!per_frame_vsync) begin
            frame_err       <= 1'b1;
            state           <= S_IDLE;
            gen_frame_vsync <= 1'b0;
            gen_frame_href  <= 1'b0;
            gen_frame_clken <= 1'b0;
            gen_img_y       <= '0;
          end else if (href_q && !per_frame_href) begin
            gen_frame_vsync <= 1'b1;
            gen_frame_href  <= 1'b1;
            gen_frame_clken <= 1'b1;
            gen_img_y       <= '0;
            if (pix_cnt != LAST_COL) begin
              line_len_err <= 1'b1;
            end
            pix_cnt <= '0;
            in_row  <= in_row + ONE;
            state   <= S_PAD;
          end else begin
            gen_frame_vsync <= per_frame_vsync;
            gen_frame_href  <= per_frame_href;
            gen_frame_clken <= per_frame_clken;
            gen_img_y       <= per_img_y;
            if (per_frame_href && per_frame_clken && (pix_cnt != COL_SAT)) begin
              pix_cnt <= pix_cnt + ONE;
            end
          end
        end
        S_PAD: begin
          gen_frame_vsync <= 1'b1;
          gen_frame_href  <= 1'b0;
          gen_frame_clken <= 1'b0;
          gen_img_y       <= '0;
          if (in_row == LAST_ROW) begin
            state <= S_GAP;
          end else if (!per_frame_vsync) begin
            frame_err       <= 1'b1;
            gen_frame_vsync <= 1'b0;
            state           <= S_IDLE;
          end else begin
            if (per_frame_href) begin
              line_len_err <= 1'b1;
            end
            state <= S_ACTIVE;
          end
        end
        S_GAP: begin
          gen_frame_vsync <= 1'b1;
          gen_frame_href  <= 1'b1;
          gen_frame_clken <= 1'b1;
          gen_img_y       <= '0;
          flush_cnt       <= '0;
          state           <= S_FLUSH;
        end
        S_FLUSH: begin
          if (per_frame_href && !href_q) begin
            frame_err <= 1'b1;
          end
          if (flush_cnt == LAST_COL) begin
            gen_frame_href  <= 1'b0;
            gen_frame_clken <= 1'b0;
            frame_done      <= 1'b1;
            state           <= S_WAIT_VS;
          end else begin
            flush_cnt <= flush_cnt + ONE;
          end
        end
        S_WAIT_VS: begin
          gen_frame_vsync <= per_frame_vsync;
          gen_frame_href  <= 1'b0;
          gen_frame_clken <= 1'b0;
          gen_img_y       <= '0;
          if (!per_frame_vsync) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Generator-side column/row counters and the two-stage window flag pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt    <= '0;
      row_cnt    <= '0;
      gen_href_q <= 1'b0;
      s1_valid   <= 1'b0;
      s1_border  <= 1'b0;
      s1_x       <= '0;
      s1_y       <= '0;
      win_valid  <= 1'b0;
      win_border <= 1'b0;
      win_x      <= '0;
      win_y      <= '0;
    end else begin
      gen_href_q <= gen_frame_href;
      if (!gen_frame_vsync) begin
        row_cnt <= '0;
      end else if (gen_href_q && !gen_frame_href && (row_cnt != LAST_ROW)) begin
        row_cnt <= row_cnt + ONE;
      end
      if (!gen_frame_href) begin
        col_cnt <= '0;
      end else if (gen_frame_clken && (col_cnt != COL_SAT)) begin
        col_cnt <= col_cnt + ONE;
      end
      s1_valid  <= win_hit;
      s1_border <= win_hit && win_edge;
      if (win_hit) begin
        s1_x <= col_cnt - ONE;
        s1_y <= row_cnt - ONE;
      end
      win_valid  <= s1_valid;
      win_border <= s1_valid && s1_border;
      if (s1_valid) begin
        win_x <= s1_x;
        win_y <= s1_y;
      end
    end
  end

endmodule
